receptor_display_spi: RTL and testbench
=======================================

// Module: receptor_display_spi
// PURPOSE
// - Receiving end of the 4-wire SPI link to the SSD1306 OLED: bit-level SPI slave, SSD1306 command decoder, 128x64 GDDRAM mirror.
// - Sits beside/in place of the panel. Used in simulation and on-chip to check the display controller and to mirror the screen to other outputs.
// - Reconstructs bytes, applies commands (display on/off, invert, contrast, address windows), writes data bytes to a 1024-byte frame buffer.
// PARAMETERS
// - COLUMNS      128  columns per page (segments)
// - PAGES        8    pages of 8 rows; buffer depth = COLUMNS*PAGES = 1024
// - SYNC_STAGES  2    flip-flop synchronizer depth on io_* inputs
// PORTS
// - clk           in   1   system clock; all logic on posedge
// - rst           in   1   synchronous, active-high reset
// - io_sclk       in   1   SPI clock; idle high; data sampled on rising edge
// - io_sdin       in   1   SPI data, MSB first
// - io_cs         in   1   chip select, active low
// - io_dc         in   1   0 = command byte, 1 = data byte; sampled with bit 0
// - io_reset      in   1   panel reset, active low
// - rd_addr       in   10  frame-buffer read address, page*128+col
// - rd_data       out  8   frame-buffer byte, 1-cycle read latency
// - byte_valid    out  1   1-cycle strobe: a full byte was received
// - byte_data     out  8   last received byte; valid with byte_valid
// - byte_is_data  out  1   io_dc captured for that byte
// - display_on    out  1   set by 0xAF, cleared by 0xAE
// - invert        out  1   set by 0xA7, cleared by 0xA6
// - entire_on     out  1   set by 0xA5, cleared by 0xA4
// - contrast      out  8   operand of 0x81
// BEHAVIOUR
// - Reset (rst=1, or synchronized io_reset=0): bit count 0, no pending operands, display_on=0, invert=0, entire_on=0, contrast=0x7F,
//   byte_valid=0, byte_data=0, col window 0..127, page window 0..7, pointer col=0 page=0. Frame-buffer contents are kept.
// - Inputs pass through SYNC_STAGES FFs. sdin/dc are delayed by the same depth as sclk. Rising edge = sync sclk 0 in previous cycle, 1 now.
//   Minimum supported sclk half-period: 1 clk.
// - On each rising edge with cs low: shift sdin into the byte. On the 8th bit, byte_valid goes high in the next cycle.
// - cs high: bit counter clears, partial byte discarded. Pending command operands are kept; cs may toggle between bytes.
// - Command FSM states: CMD_IDLE, CMD_ARG1, CMD_ARG2.
//   - 1-operand opcodes 0x81,0x20,0xA8,0xD3,0xD5,0xD9,0xDB,0x8D: IDLE->ARG1->IDLE.
//   - 2-operand opcodes 0x21 (col start,end) and 0x22 (page start,end): IDLE->ARG1->ARG2->IDLE.
//     Writing the window also moves the pointer to (start).
//   - All other opcodes are single-byte. Unknown opcodes are ignored.
// - Operand widths: col operands masked to 7 bits, page operands to 3 bits. end<start is treated as end=start.
// - A data byte arriving in ARG1/ARG2 is written to RAM. The command FSM returns to IDLE and the operand is lost.
// - Data byte: write mem[page*128+col] in the same cycle byte_valid asserts. Then advance in horizontal mode:
//   - col==col_end: col=col_start; page = (page==page_end) ? page_start : page+1
//   - otherwise col+1
//   - Full window: byte 1025 wraps to address 0.
// - Addressing-mode operand of 0x20 is stored but only horizontal mode is implemented.
// - Read port is independent of writes. Same-cycle read/write to one address returns the old data.
// - rst asserted mid-byte: partial byte dropped. The next byte starts at bit 7 after release.
// STRUCTURE
// - Package receptor_display_pkg: opcode localparams (OP_DISPLAY_OFF=8'hAE, OP_CONTRAST=8'h81, ...),
//   command-state encodings, COLUMNS/PAGES defaults.
// - Sub-module spi_deserializador: synchronizers, edge detect, shift register, byte_valid/byte_is_data.
// - Top level: command FSM, address pointer, 1024x8 RAM inferred as block RAM.
// TESTING
// - Power-up: rst 3 cycles -> display_on=0, contrast=0x7F, byte_valid low. Then send the 23-byte init sequence (0xAE...0xAF, dc=0)
//   -> 23 strobes, display_on=1, contrast=0x7F, invert=0, entire_on=0.
// - Send 0x81,0x33 then 0xA7 (dc=0) -> contrast=0x33, invert=1. No RAM writes.
// - Send 1024 data bytes i%256, then a 1025th byte 0xAA -> rd_addr=5 gives 0x05; rd_addr=0 gives 0xAA (wrap).
// - Send 0x21,0x10,0x11 and 0x22,0x02,0x03, then 5 data bytes 1..5 -> bytes land at addresses 272,273,400,401,272 (value 5).
// - Raise cs after 4 bits of a byte, lower it, send 0x3C as data -> exactly one strobe, byte_data=0x3C, written to the current pointer.
// - Pulse io_reset low for 4 cycles mid-stream -> display_on=0, pointer (0,0); previous RAM contents still readable.

Source files
------------

// File: rtl/receptor_display_pkg.sv
// Shared definitions for the SSD1306 SPI receiver: opcodes, command states
// and the reset image of the display configuration registers.
package receptor_display_pkg;

    localparam int COLUMNS_DEF     = 128;
    localparam int PAGES_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] OP_NORMAL      = 8'hA6;
    localparam logic [7:0] OP_INVERT      = 8'hA7;
    localparam logic [7:0] OP_RAM_DISPLAY = 8'hA4;
    localparam logic [7:0] OP_ENTIRE_ON   = 8'hA5;
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
    localparam logic [7:0] OP_COL_ADDR    = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OP_VCOMH       = 8'hDB;
    localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;

    typedef enum logic [1:0] {
        CMD_IDLE = 2'd0,
        CMD_ARG1 = 2'd1,
        CMD_ARG2 = 2'd2
    } cmd_state_t;

    typedef struct packed {
        logic       display_on;
        logic       invert;
        logic       entire_on;
        logic [7:0] contrast;
        logic [1:0] addr_mode;
    } disp_cfg_t;

    localparam disp_cfg_t CFG_RESET = '{
        display_on: 1'b0,
        invert:     1'b0,
        entire_on:  1'b0,
        contrast:   8'h7F,
        addr_mode:  2'b00
    };

endpackage

// File: rtl/spi_deserializador.sv
// SPI slave front end: synchronizes the panel pins, detects sclk rising
// edges and assembles MSB-first bytes into a one-cycle strobe.
module spi_deserializador
    import receptor_display_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_sclk,
    input  logic       io_sdin,
    input  logic       io_cs,
    input  logic       io_dc,
    input  logic       io_reset,
    output logic       link_rst,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data
);

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] sdin_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] dc_sr;
    logic [SYNC_STAGES-1:0] nres_sr;
    logic                   sclk_prev;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;

    logic sclk_s;
    logic sdin_s;
    logic cs_s;
    logic dc_s;
    logic rise;
    logic clear;

    assign sclk_s   = sclk_sr[SYNC_STAGES-1];
    assign sdin_s   = sdin_sr[SYNC_STAGES-1];
    assign cs_s     = cs_sr[SYNC_STAGES-1];
    assign dc_s     = dc_sr[SYNC_STAGES-1];
    assign link_rst = ~nres_sr[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_prev;
    assign clear    = rst | link_rst;

    // All pins share one depth so sdin/dc stay aligned with the sclk edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sr   <= '1;
            sdin_sr   <= '0;
            cs_sr     <= '1;
            dc_sr     <= '0;
            nres_sr   <= '1;
            sclk_prev <= 1'b1;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], io_sclk};
            sdin_sr   <= {sdin_sr[SYNC_STAGES-2:0], io_sdin};
            cs_sr     <= {cs_sr[SYNC_STAGES-2:0], io_cs};
            dc_sr     <= {dc_sr[SYNC_STAGES-2:0], io_dc};
            nres_sr   <= {nres_sr[SYNC_STAGES-2:0], io_reset};
            sclk_prev <= sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            bit_cnt      <= 3'd0;
            shreg        <= 7'd0;
            byte_valid   <= 1'b0;
            byte_data    <= 8'd0;
            byte_is_data <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_s) begin
                bit_cnt <= 3'd0;
            end else if (rise) begin
                shreg   <= {shreg[5:0], sdin_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid   <= 1'b1;
                    byte_data    <= {shreg, sdin_s};
                    byte_is_data <= dc_s;
                end
            end
        end
    end

endmodule

// File: rtl/receptor_display_spi.sv
// SSD1306 receiver: command decoder, horizontal-mode address pointer and a
// GDDRAM mirror with an independent registered read port.
module receptor_display_spi
    import receptor_display_pkg::*;
#(
    parameter int COLUMNS     = COLUMNS_DEF,
    parameter int PAGES       = PAGES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int CW         = $clog2(COLUMNS),
    localparam int PW         = $clog2(PAGES),
    localparam int AW         = CW + PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          io_sclk,
    input  logic          io_sdin,
    input  logic          io_cs,
    input  logic          io_dc,
    input  logic          io_reset,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          byte_valid,
    output logic [7:0]    byte_data,
    output logic          byte_is_data,
    output logic          display_on,
    output logic          invert,
    output logic          entire_on,
    output logic [7:0]    contrast
);

    logic link_rst;
    logic clear;

    spi_deserializador #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_des (
        .clk          (clk),
        .rst          (rst),
        .io_sclk      (io_sclk),
        .io_sdin      (io_sdin),
        .io_cs        (io_cs),
        .io_dc        (io_dc),
        .io_reset     (io_reset),
        .link_rst     (link_rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data)
    );

    assign clear = rst | link_rst;

    cmd_state_t    state, state_n;
    logic [7:0]    op, op_n;
    logic [CW-1:0] arg, arg_n;
    disp_cfg_t     cfg, cfg_n;
    logic [CW-1:0] col, col_n, col_start, col_start_n, col_end, col_end_n;
    logic [PW-1:0] page, page_n, pg_start, pg_start_n, pg_end, pg_end_n;
    logic          we;
    logic [AW-1:0] waddr;

    logic [CW-1:0] b_col;
    logic [PW-1:0] b_pg;
    logic [PW-1:0] a_pg;

    assign b_col = byte_data[CW-1:0];
    assign b_pg  = byte_data[PW-1:0];
    assign a_pg  = arg[PW-1:0];
    assign waddr = {page, col};

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= CMD_IDLE;
            op        <= 8'd0;
            arg       <= '0;
            cfg       <= CFG_RESET;
            col       <= '0;
            page      <= '0;
            col_start <= '0;
            col_end   <= CW'(COLUMNS - 1);
            pg_start  <= '0;
            pg_end    <= PW'(PAGES - 1);
        end else begin
            state     <= state_n;
            op        <= op_n;
            arg       <= arg_n;
            cfg       <= cfg_n;
            col       <= col_n;
            page      <= page_n;
            col_start <= col_start_n;
            col_end   <= col_end_n;
            pg_start  <= pg_start_n;
            pg_end    <= pg_end_n;
        end
    end

    always_comb begin
        state_n     = state;
        op_n        = op;
        arg_n       = arg;
        cfg_n       = cfg;
        col_n       = col;
        page_n      = page;
        col_start_n = col_start;
        col_end_n   = col_end;
        pg_start_n  = pg_start;
        pg_end_n    = pg_end;
        we          = 1'b0;
        if (byte_valid) begin
            if (byte_is_data) begin
                // Data aborts any half-received command; its operand is lost
                we      = 1'b1;
                state_n = CMD_IDLE;
                if (col == col_end) begin
                    col_n  = col_start;
                    page_n = (page == pg_end) ? pg_start : page + 1'b1;
                end else begin
                    col_n = col + 1'b1;
                end
            end else begin
                unique case (state)
                    CMD_IDLE: begin
                        op_n = byte_data;
                        case (byte_data)
                            OP_DISPLAY_OFF: cfg_n.display_on = 1'b0;
                            OP_DISPLAY_ON:  cfg_n.display_on = 1'b1;
                            OP_NORMAL:      cfg_n.invert     = 1'b0;
                            OP_INVERT:      cfg_n.invert     = 1'b1;
                            OP_RAM_DISPLAY: cfg_n.entire_on  = 1'b0;
                            OP_ENTIRE_ON:   cfg_n.entire_on  = 1'b1;
                            OP_CONTRAST, OP_ADDR_MODE, OP_MUX_RATIO,
                            OP_DISP_OFFSET, OP_CLK_DIV, OP_PRECHARGE,
                            OP_VCOMH, OP_CHARGE_PUMP,
                            OP_COL_ADDR, OP_PAGE_ADDR:
                                state_n = CMD_ARG1;
                            default: ;
                        endcase
                    end
                    CMD_ARG1: begin
                        state_n = CMD_IDLE;
                        arg_n   = b_col;
                        case (op)
                            OP_CONTRAST:  cfg_n.contrast  = byte_data;
                            OP_ADDR_MODE: cfg_n.addr_mode = byte_data[1:0];
                            OP_COL_ADDR, OP_PAGE_ADDR: state_n = CMD_ARG2;
                            default: ;
                        endcase
                    end
                    CMD_ARG2: begin
                        state_n = CMD_IDLE;
                        // An end below start collapses the window to start
                        case (op)
                            OP_COL_ADDR: begin
                                col_start_n = arg;
                                col_end_n   = (b_col < arg) ? arg : b_col;
                                col_n       = arg;
                            end
                            OP_PAGE_ADDR: begin
                                pg_start_n = a_pg;
                                pg_end_n   = (b_pg < a_pg) ? a_pg : b_pg;
                                page_n     = a_pg;
                            end
                            default: ;
                        endcase
                    end
                    default: state_n = CMD_IDLE;
                endcase
            end
        end
    end

    assign display_on = cfg.display_on;
    assign invert     = cfg.invert;
    assign entire_on  = cfg.entire_on;
    assign contrast   = cfg.contrast;

    // Frame buffer survives resets; read-before-write on address collision
    logic [7:0] mem [COLUMNS*PAGES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= byte_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_receptor_display_spi.sv
// Directed bench for receptor_display_spi: SPI byte driver, strobe scoreboard
// and frame-buffer readback checks.
module tb_receptor_display_spi;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_sclk;
    logic       io_sdin;
    logic       io_cs;
    logic       io_dc;
    logic       io_reset;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_is_data;
    logic       display_on;
    logic       invert;
    logic       entire_on;
    logic [7:0] contrast;

    receptor_display_spi dut (
        .clk          (clk),
        .rst          (rst),
        .io_sclk      (io_sclk),
        .io_sdin      (io_sdin),
        .io_cs        (io_cs),
        .io_dc        (io_dc),
        .io_reset     (io_reset),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data),
        .display_on   (display_on),
        .invert       (invert),
        .entire_on    (entire_on),
        .contrast     (contrast)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    logic [8:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && byte_valid === 1'b1) begin
            logic [8:0] e;
            n_strobe++;
            check("sb_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_byte", 32'(byte_data), 32'(e[7:0]));
                check("sb_dc", 32'(byte_is_data), 32'(e[8]));
            end
        end
    end

    task automatic send_bits(input logic [7:0] b, input logic d,
                             input int n);
        io_cs = 1'b0;
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            io_sclk = 1'b0;
            io_sdin = b[i];
            io_dc   = d;
            repeat (2) @(negedge clk);
            io_sclk = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        exp_q.push_back({d, b});
        send_bits(b, d, 8);
        repeat (6) @(negedge clk);
    endtask

    task automatic rd(input logic [9:0] a, input logic [7:0] e,
                      input string tag);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(e));
    endtask

    logic [7:0] init_seq [23] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA5, 8'hA4, 8'hA6, 8'h2E, 8'hAF
    };

    initial begin
        int s0;
        rst      = 1'b1;
        io_sclk  = 1'b1;
        io_sdin  = 1'b0;
        io_cs    = 1'b1;
        io_dc    = 1'b0;
        io_reset = 1'b1;
        rd_addr  = '0;
        repeat (3) @(negedge clk);
        check("rst_display_on", 32'(display_on), 32'd0);
        check("rst_contrast", 32'(contrast), 32'h7F);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            send_byte(init_seq[i], 1'b0);
            if (i == 18) check("entire_on_set", 32'(entire_on), 32'd1);
        end
        check("init_strobes", n_strobe, 32'd23);
        check("init_display_on", 32'(display_on), 32'd1);
        check("init_contrast", 32'(contrast), 32'h7F);
        check("init_invert", 32'(invert), 32'd0);
        check("init_entire_on", 32'(entire_on), 32'd0);

        send_byte(8'h81, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'hA7, 1'b0);
        check("contrast_33", 32'(contrast), 32'h33);
        check("invert_set", 32'(invert), 32'd1);

        for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b1);
        send_byte(8'hAA, 1'b1);
        rd(10'd5, 8'h05, "fill_addr5");
        rd(10'd0, 8'hAA, "wrap_addr0");
        rd(10'd1, 8'h01, "fill_addr1");
        rd(10'd1023, 8'hFF, "fill_addr1023");

        send_byte(8'h21, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        rd(10'd272, 8'h05, "win_272");
        rd(10'd273, 8'h02, "win_273");
        rd(10'd400, 8'h03, "win_400");
        rd(10'd401, 8'h04, "win_401");
        rd(10'd274, 8'h12, "win_274_untouched");

        s0 = n_strobe;
        send_bits(8'hF0, 1'b1, 4);
        @(negedge clk);
        io_cs = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'h3C, 1'b1);
        check("abort_one_strobe", n_strobe - s0, 32'd1);
        rd(10'd273, 8'h3C, "abort_write_273");

        send_byte(8'h81, 1'b0);
        send_byte(8'h77, 1'b1);
        send_byte(8'hA6, 1'b0);
        check("arg_lost_contrast", 32'(contrast), 32'h33);
        check("arg_lost_invert", 32'(invert), 32'd0);
        rd(10'd400, 8'h77, "arg_data_400");

        send_byte(8'h21, 1'b0);
        send_byte(8'h50, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hE1, 1'b1);
        send_byte(8'hE2, 1'b1);
        rd(10'd720, 8'hE2, "collapsed_720");
        rd(10'd721, 8'hD1, "collapsed_721");

        send_bits(8'h5A, 1'b1, 4);
        io_reset = 1'b0;
        repeat (4) @(negedge clk);
        io_reset = 1'b1;
        repeat (6) @(negedge clk);
        check("ioreset_display_on", 32'(display_on), 32'd0);
        check("ioreset_contrast", 32'(contrast), 32'h7F);
        check("ioreset_byte_valid", 32'(byte_valid), 32'd0);
        send_byte(8'h99, 1'b1);
        rd(10'd0, 8'h99, "ioreset_ptr0");
        rd(10'd720, 8'hE2, "ioreset_keep_720");
        rd(10'd401, 8'h04, "ioreset_keep_401");

        repeat (10) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
